arith_seq: RTL
==============

# arith_seq

Sequencer for the MIX arithmetic datapath (add, sub, mul, div units). Accepts one arithmetic request from the instruction controller, routes sign-magnitude operands from rA, rX and memory word V to the selected unit, and issues a single-cycle `start`. It waits the unit's fixed latency, then captures the results and returns them with rA/rX write enables and an overflow indication. Only one operation is in flight at a time; the block sits between the control FSM and the shared arithmetic units.

## Interface
- ADD_LAT, default 2: cycles from add/sub `start` to valid result (1..15)
- MUL_LAT, default 10: cycles from mul `start` to valid product (1..15)
- DIV_LAT, default 12: cycles from div `start` to valid quotient/remainder (1..15)

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  request strobe; sampled only in IDLE
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 DIV
- a_in / x_in / v_in  in  31 each  rA, rX, V; bit 30 sign, [29:0] magnitude
- busy  out  1  high from acceptance edge through DONE
- done  out  1  one-cycle completion pulse
- a_we / x_we  out  1 each  write strobes, valid with `done`
- a_out / x_out  out  31 each  results, valid with `done`
- ovf  out  1  set-overflow-toggle strobe, valid with `done`
- add_start, sub_start, mul_start, div_start  out  1 each  one-cycle unit starts
- in1 / in2  out  31 each  operand bus to add/sub/mul (in1 = rA, in2 = V)
- dividend  out  61  {a_in[30], a_in[29:0], x_in[29:0]}
- divisor  out  31  = V
- sum_in / diff_in  in  32 each  {carry, sign, magnitude} from add/sub
- prod_in  in  61  {sign, 60-bit magnitude}
- quot_in / rem_in  in  31 each
- div_ovf_in  in  1  divide overflow from div unit

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, req=1: latch op and operands (in1, in2, dividend, divisor held stable until next acceptance) → ISSUE; busy=1.
- ISSUE: exactly one `*_start` high for this cycle; cnt ← LAT−1 of selected unit → WAIT.
- WAIT: cnt decrements each cycle; at cnt=0 capture results → DONE.
- DONE: done=1 one cycle → IDLE; busy falls at the same edge.
- ADD/SUB: a_out = result[30:0], a_we=1, x_we=0, ovf = result[31].
- MUL: a_out = {prod[60], prod[59:30]}, x_out = {prod[60], prod[29:0]}; both we=1; ovf=0.
- DIV: a_out = quot_in, x_out = rem_in, both we=1 when div_ovf_in=0; if div_ovf_in=1: ovf=1, a_we=x_we=0.
- req during busy ignored (not queued). Operands changing after acceptance have no effect.
- Reset: all outputs 0, state IDLE, cnt 0. Reset mid-operation aborts; no done, no write strobes; any unit result is discarded.

## Timing
- Acceptance edge E0. `*_start` high between E0 and E1. done high between E(LAT+1) and E(LAT+2).
- Total occupancy LAT+2 cycles; next req accepted at E(LAT+2) at the earliest (back-to-back allowed when req is held).
- All outputs registered; no combinational path from req/op to any output.
- cnt is 4 bits.

## Configuration
- ARITH_DIVCHK_EN defined: on DIV acceptance, if divisor magnitude = 0 or |a_in[29:0]| ≥ |v_in[29:0]|, skip ISSUE/WAIT; no div_start; DONE on next cycle with ovf=1, a_we=x_we=0 (2-cycle occupancy).
- Undefined: divide always issued to the unit; overflow taken solely from div_ovf_in.

## Test plan
- ADD +123 + +123 (ADD_LAT=2) → add_start high in cycle after E0, done in cycle after E3, a_out=+246, a_we=1, x_we=0, ovf=0.
- SUB +123 − (−123) → sub_start only, a_out=+246; ADD +0o7777777777 + +1 → ovf=1, a_out magnitude 0.
- MUL +123 × −123 (MUL_LAT=10) → done after E11, a_out={1,0}, x_out={1,30'd15129}, both we=1.
- DIV rA:rX = +50, V = −17 → quot −2 in a_out, rem +16 in x_out; with ARITH_DIVCHK_EN, V=+0 → no div_start, done after E1, ovf=1, no writes.
- req pulsed twice during WAIT → ignored; exactly one done; busy continuous.
- reset asserted in WAIT → busy, done, strobes 0 immediately; after release, new ADD completes normally.

Source files
------------

// File: rtl/arith_seq.sv
// arith_seq: MIX arithmetic sequencer (add/sub/mul/div issue, wait, capture); optional ARITH_DIVCHK_EN early divide-overflow check
module arith_seq #(
    parameter int ADD_LAT = 2,
    parameter int MUL_LAT = 10,
    parameter int DIV_LAT = 12
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic [1:0]  i_op,
    input  logic [30:0] i_a_in,
    input  logic [30:0] i_x_in,
    input  logic [30:0] i_v_in,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_a_we,
    output logic        o_x_we,
    output logic [30:0] o_a_out,
    output logic [30:0] o_x_out,
    output logic        o_ovf,
    output logic        o_add_start,
    output logic        o_sub_start,
    output logic        o_mul_start,
    output logic        o_div_start,
    output logic [30:0] o_in1,
    output logic [30:0] o_in2,
    output logic [60:0] o_dividend,
    output logic [30:0] o_divisor,
    input  logic [31:0] i_sum_in,
    input  logic [31:0] i_diff_in,
    input  logic [60:0] i_prod_in,
    input  logic [30:0] i_quot_in,
    input  logic [30:0] i_rem_in,
    input  logic        i_div_ovf_in
);
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;
    localparam logic [3:0] ADD_CNT = 4'(ADD_LAT - 1);
    localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    logic [1:0]  r_op;
    logic [3:0]  r_cnt;
    logic        r_skip;
    logic        r_busy;
    logic        r_done;
    logic        r_a_we;
    logic        r_x_we;
    logic        r_ovf;
    logic [30:0] r_a_out;
    logic [30:0] r_x_out;
    logic        r_add_start;
    logic        r_sub_start;
    logic        r_mul_start;
    logic        r_div_start;
    logic [30:0] r_in1;
    logic [30:0] r_in2;
    logic [60:0] r_dividend;
    logic [30:0] r_divisor;

    logic        w_accept;
    logic        w_skip;
    logic [3:0]  w_lat;
    logic        w_is_add;
    logic        w_is_sub;
    logic        w_is_mul;
    logic        w_is_div;
    logic [30:0] w_a_res;
    logic [30:0] w_x_res;
    logic        w_a_we;
    logic        w_x_we;
    logic        w_ovf;
    logic        w_unused;

    // DONE is the last busy cycle, so a held request starts the next operation without an idle gap
    assign w_accept = i_req && (r_state == S_IDLE || r_state == S_DONE);

`ifdef ARITH_DIVCHK_EN
    // A zero divisor or |rA| >= |V| cannot give a 30-bit quotient, so the unit is never started
    assign w_skip = (i_op == OP_DIV) && ((i_v_in[29:0] == 30'd0) || (i_a_in[29:0] >= i_v_in[29:0]));
`else
    assign w_skip = 1'b0;
`endif

    assign w_is_add = r_op == OP_ADD;
    assign w_is_sub = r_op == OP_SUB;
    assign w_is_mul = r_op == OP_MUL;
    assign w_is_div = r_op == OP_DIV;
    assign w_lat    = w_is_mul ? MUL_CNT : w_is_div ? DIV_CNT : ADD_CNT;

    // Results from the unit selected by the latched opcode; the 60-bit product splits into rA (high) and rX (low)
    assign w_a_res = w_is_add ? i_sum_in[30:0] :
                     w_is_sub ? i_diff_in[30:0] :
                     w_is_mul ? {i_prod_in[60], i_prod_in[59:30]} : i_quot_in;
    assign w_x_res = w_is_mul ? {i_prod_in[60], i_prod_in[29:0]} : i_rem_in;
    assign w_a_we  = !(w_is_div && i_div_ovf_in);
    assign w_x_we  = w_is_mul || (w_is_div && !i_div_ovf_in);
    assign w_ovf   = w_is_add ? i_sum_in[31] : w_is_sub ? i_diff_in[31] : w_is_div && i_div_ovf_in;

    // rX sign plays no part in the double-length dividend
    assign w_unused = i_x_in[30];

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_a_we      = r_a_we;
    assign o_x_we      = r_x_we;
    assign o_ovf       = r_ovf;
    assign o_a_out     = r_a_out;
    assign o_x_out     = r_x_out;
    assign o_add_start = r_add_start;
    assign o_sub_start = r_sub_start;
    assign o_mul_start = r_mul_start;
    assign o_div_start = r_div_start;
    assign o_in1       = r_in1;
    assign o_in2       = r_in2;
    assign o_dividend  = r_dividend;
    assign o_divisor   = r_divisor;

    // Sequencer: accept, pulse one start, count the unit latency, capture and report for one cycle
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_ADD;
            r_cnt       <= 4'd0;
            r_skip      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_a_we      <= 1'b0;
            r_x_we      <= 1'b0;
            r_ovf       <= 1'b0;
            r_a_out     <= 31'd0;
            r_x_out     <= 31'd0;
            r_add_start <= 1'b0;
            r_sub_start <= 1'b0;
            r_mul_start <= 1'b0;
            r_div_start <= 1'b0;
            r_in1       <= 31'd0;
            r_in2       <= 31'd0;
            r_dividend  <= 61'd0;
            r_divisor   <= 31'd0;
        end else begin
            r_add_start <= 1'b0;
            r_sub_start <= 1'b0;
            r_mul_start <= 1'b0;
            r_div_start <= 1'b0;
            r_done      <= 1'b0;
            r_a_we      <= 1'b0;
            r_x_we      <= 1'b0;
            r_ovf       <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_busy <= w_accept;
                    r_state <= w_accept ? S_ISSUE : S_IDLE;
                    if (w_accept) begin
                        r_op        <= i_op;
                        r_skip      <= w_skip;
                        r_in1       <= i_a_in;
                        r_in2       <= i_v_in;
                        r_dividend  <= {i_a_in[30], i_a_in[29:0], i_x_in[29:0]};
                        r_divisor   <= i_v_in;
                        r_add_start <= i_op == OP_ADD;
                        r_sub_start <= i_op == OP_SUB;
                        r_mul_start <= i_op == OP_MUL;
                        r_div_start <= (i_op == OP_DIV) && !w_skip;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= w_lat;
                    r_state <= r_skip ? S_DONE : S_WAIT;
                    r_done  <= r_skip;
                    r_ovf   <= r_skip;
                end
                S_WAIT: begin
                    r_cnt <= (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
                    if (r_cnt == 4'd0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_a_we  <= w_a_we;
                        r_x_we  <= w_x_we;
                        r_ovf   <= w_ovf;
                        if (w_a_we) r_a_out <= w_a_res;
                        if (w_x_we) r_x_out <= w_x_res;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
